pipeline_stage_register: RTL and testbench
==========================================

PIPELINE_STAGE_REGISTER -- requirements
Module: pipeline_stage_register

Interface
REQ-001 SHALL have parameter WIDTH, default 32: payload width in bits, at least 1.
REQ-002 SHALL have parameter NOP_VALUE, default 32'h2A2A_2A2A (WIDTH bits): Out_Data value when the stage is empty or flushed.
REQ-003 SHALL have parameter SKID_EN, default 1:
- 1 = two-entry skid mode with registered In_Ready.
- 0 = single-entry mode with combinational In_Ready.
REQ-004 SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port Flush, input, 1 bit: discard all held entries this cycle.
REQ-007 SHALL have port In_Valid, input, 1 bit: upstream offers In_Data.
REQ-008 SHALL have port In_Data, input, WIDTH bits: upstream payload.
REQ-009 SHALL have port In_Ready, output, 1 bit: the stage can accept a payload.
REQ-010 SHALL have port Out_Valid, output, 1 bit: Out_Data holds a live entry.
REQ-011 SHALL have port Out_Data, output, WIDTH bits: payload of the head entry.
REQ-012 SHALL have port Out_Ready, input, 1 bit: downstream accepts the head entry.
REQ-013 SHALL have port Count, output, 2 bits: number of held entries (0-2).

Function
REQ-014 SHALL define an accept as In_Valid and In_Ready high at a rising edge, and a release as Out_Valid and Out_Ready high at a rising edge.
REQ-015 SHALL present an accepted payload on Out_Data with Out_Valid high exactly one cycle after the accept (latency 1).
REQ-016 SHALL, in skid mode, implement states EMPTY, FULL and SKID:
- EMPTY: accept -> FULL.
- FULL: accept and release -> FULL with the new payload at the head.
- FULL: accept, no release -> SKID; the new payload goes into the skid entry.
- FULL: release, no accept -> EMPTY.
- SKID: release -> FULL; the skid entry moves to the head.
- Otherwise hold state.
REQ-017 SHALL, in skid mode, drive In_Ready = (state != SKID) directly from a flop, with no combinational path from Out_Ready.
REQ-018 SHALL, in single-entry mode, use only EMPTY and FULL, with In_Ready = !Out_Valid || Out_Ready.
REQ-019 SHALL drive Out_Valid = (state != EMPTY) and Count = 0, 1 or 2 for EMPTY, FULL and SKID respectively.
REQ-020 SHALL hold Out_Data stable while Out_Valid is high and Out_Ready is low.
REQ-021 SHALL drive Out_Data = NOP_VALUE whenever the state is EMPTY.
REQ-022 SHALL give Flush priority over accept and release: next state EMPTY, both entries discarded, and any same-cycle accept dropped.
REQ-023 SHALL never reorder, duplicate or drop payloads except under Flush or RST.
REQ-024 SHALL not accept anything while In_Valid is low, whatever In_Data holds.

Reset
REQ-025 SHALL, on RST high at a rising edge, enter EMPTY with Out_Valid=0, Count=0, Out_Data=NOP_VALUE, and In_Ready=1 in skid mode.
REQ-026 SHALL give RST priority over Flush, accept and release, including RST asserted while in SKID.
REQ-027 SHALL accept new data on the first edge after RST deasserts.

Structure
REQ-028 SHALL place the state enumeration stage_state_t (EMPTY, FULL, SKID) and the constant NOP_PATTERN = 32'h2A2A_2A2A in the shared definitions package.
REQ-029 SHALL be a single module with no sub-modules; the head and skid entries are plain WIDTH-bit registers.

Verification
REQ-030 SHALL check pass-through: SKID_EN=1, Out_Ready=1, In_Data 32'h1111_0000..32'h1111_0004 on five consecutive cycles -> each appears on Out_Data one cycle later, with Count=1 and In_Ready=1 throughout.
REQ-031 SHALL check backpressure: Out_Ready=0 while 32'hA, 32'hB, 32'hC are offered -> A and B accepted, Count=2, In_Ready=0, C held upstream; raising Out_Ready then releases A, B, C in order.
REQ-032 SHALL check flush in SKID: Flush=1 with In_Valid=1, In_Data=32'hDEAD -> next cycle Out_Valid=0, Count=0, Out_Data=32'h2A2A_2A2A, and 32'hDEAD never emitted.
REQ-033 SHALL check reset priority: RST=1 and Flush=1 together while in FULL with In_Valid=1 -> next cycle EMPTY, Out_Data=32'h2A2A_2A2A; with RST=0, 32'h5 accepted on the next edge.
REQ-034 SHALL check single-entry mode: SKID_EN=0, FULL, Out_Ready=1 and In_Valid=1 in the same cycle -> In_Ready=1 combinationally, and back-to-back payloads are released with no bubble.
REQ-035 SHALL randomise valid/ready for 1000 cycles against a scoreboard, checking order, no loss, and Count never exceeding 2 (never exceeding 1 when SKID_EN=0).

Source files
------------

// File: rtl/pipeline_stage_register_pkg.sv
// Shared definitions for the pipeline stage register: state encoding,
// default bubble pattern and a state-to-occupancy helper.
package pipeline_stage_register_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } stage_state_t;

    localparam logic [31:0] NOP_PATTERN = 32'h2A2A_2A2A;

    function automatic logic [1:0] state_count(input stage_state_t s);
        case (s)
            EMPTY:   return 2'd0;
            FULL:    return 2'd1;
            SKID:    return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipeline_stage_register.sv
// Valid/ready pipeline stage: two-entry skid buffer with a registered
// In_Ready, or a single-entry register with combinational In_Ready.
module pipeline_stage_register
    import pipeline_stage_register_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] NOP_VALUE = WIDTH'(NOP_PATTERN),
    parameter bit               SKID_EN   = 1'b1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Flush,
    input  logic             In_Valid,
    input  logic [WIDTH-1:0] In_Data,
    output logic             In_Ready,
    output logic             Out_Valid,
    output logic [WIDTH-1:0] Out_Data,
    input  logic             Out_Ready,
    output logic [1:0]       Count
);

    stage_state_t     state_q, state_d;
    logic [WIDTH-1:0] head_q, skid_q;
    logic             load_head, head_from_skid, load_skid;
    logic             accept, release_hd;

    assign accept     = In_Valid && In_Ready;
    assign release_hd = Out_Valid && Out_Ready;

    always_ff @(posedge CLK) begin
        if (RST) state_q <= EMPTY;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d        = state_q;
        load_head      = 1'b0;
        head_from_skid = 1'b0;
        load_skid      = 1'b0;
        if (Flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d   = FULL;
                        load_head = 1'b1;
                    end
                end
                FULL: begin
                    if (accept && release_hd) begin
                        load_head = 1'b1;
                    end else if (accept && SKID_EN) begin
                        // downstream stalled: park the newcomer behind the head
                        state_d   = SKID;
                        load_skid = 1'b1;
                    end else if (release_hd) begin
                        state_d = EMPTY;
                    end
                end
                SKID: begin
                    if (release_hd) begin
                        state_d        = FULL;
                        load_head      = 1'b1;
                        head_from_skid = 1'b1;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            head_q <= NOP_VALUE;
            skid_q <= NOP_VALUE;
        end else begin
            if (load_head) head_q <= head_from_skid ? skid_q : In_Data;
            if (load_skid) skid_q <= In_Data;
        end
    end

    always_comb begin
        Out_Valid = (state_q != EMPTY);
        Count     = state_count(state_q);
        Out_Data  = (state_q == EMPTY) ? NOP_VALUE : head_q;
    end

    generate
        if (SKID_EN) begin : g_skid_ready
            logic ready_q;
            // registered so In_Ready has no path from Out_Ready
            always_ff @(posedge CLK) begin
                if (RST) ready_q <= 1'b1;
                else     ready_q <= (state_d != SKID);
            end
            assign In_Ready = ready_q;
        end else begin : g_comb_ready
            assign In_Ready = !Out_Valid || Out_Ready;
        end
    endgenerate

endmodule

// File: tb/tb_pipeline_stage_register.sv
// Bench for pipeline_stage_register: skid and single-entry instances share
// stimulus and are each compared every cycle against a queue model.
module tb_pipeline_stage_register;

    localparam logic [31:0] NOP  = 32'h2A2A_2A2A;
    localparam logic [31:0] DEAD = 32'h0000_DEAD;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        Flush = 1'b0;
    logic        In_Valid = 1'b0;
    logic [31:0] In_Data = 32'h0;
    logic        Out_Ready = 1'b0;

    logic        s_ready, s_valid, o_ready, o_valid;
    logic [31:0] s_data, o_data;
    logic [1:0]  s_count, o_count;

    int vectors = 0;
    int miscompares = 0;
    bit armed = 1'b0;
    bit watch_dead = 1'b1;
    bit saw_dead = 1'b0;

    logic [31:0] mq_s[$];
    logic [31:0] mq_o[$];

    always #5 CLK = ~CLK;

    pipeline_stage_register #(.WIDTH(32), .NOP_VALUE(NOP), .SKID_EN(1'b1)) u_skid (
        .CLK(CLK), .RST(RST), .Flush(Flush),
        .In_Valid(In_Valid), .In_Data(In_Data), .In_Ready(s_ready),
        .Out_Valid(s_valid), .Out_Data(s_data), .Out_Ready(Out_Ready),
        .Count(s_count)
    );

    pipeline_stage_register #(.WIDTH(32), .NOP_VALUE(NOP), .SKID_EN(1'b0)) u_one (
        .CLK(CLK), .RST(RST), .Flush(Flush),
        .In_Valid(In_Valid), .In_Data(In_Data), .In_Ready(o_ready),
        .Out_Valid(o_valid), .Out_Data(o_data), .Out_Ready(Out_Ready),
        .Count(o_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Model: a FIFO of held payloads; capacity 2 (skid) or 1 (single entry).
    always @(posedge CLK) begin
        bit acc, rel;
        if (RST) begin
            mq_s.delete();
            mq_o.delete();
            armed = 1'b1;
        end else if (Flush) begin
            mq_s.delete();
            mq_o.delete();
        end else begin
            acc = In_Valid && (mq_s.size() < 2);
            rel = (mq_s.size() > 0) && Out_Ready;
            if (rel) void'(mq_s.pop_front());
            if (acc) mq_s.push_back(In_Data);
            acc = In_Valid && ((mq_o.size() == 0) || Out_Ready);
            rel = (mq_o.size() > 0) && Out_Ready;
            if (rel) void'(mq_o.pop_front());
            if (acc) mq_o.push_back(In_Data);
        end
    end

    always @(negedge CLK) begin
        if (armed) begin
            chk("s_valid", 32'(s_valid), 32'(mq_s.size() > 0));
            chk("s_data",  s_data, (mq_s.size() > 0) ? mq_s[0] : NOP);
            chk("s_count", 32'(s_count), mq_s.size());
            chk("s_ready", 32'(s_ready), 32'(mq_s.size() < 2));
            chk("s_count_max", 32'(s_count <= 2'd2), 32'd1);
            chk("o_valid", 32'(o_valid), 32'(mq_o.size() > 0));
            chk("o_data",  o_data, (mq_o.size() > 0) ? mq_o[0] : NOP);
            chk("o_count", 32'(o_count), mq_o.size());
            chk("o_ready", 32'(o_ready), 32'((mq_o.size() == 0) || Out_Ready));
            chk("o_count_max", 32'(o_count <= 2'd1), 32'd1);
            if (watch_dead && ((s_valid && s_data == DEAD) || (o_valid && o_data == DEAD)))
                saw_dead = 1'b1;
        end
    end

    initial begin
        tick();
        tick();
        chk("rst_valid", 32'(s_valid), 32'd0);
        chk("rst_count", 32'(s_count), 32'd0);
        chk("rst_data",  s_data, NOP);
        chk("rst_ready", 32'(s_ready), 32'd1);
        RST = 1'b0;

        // pass-through, both modes stream with no bubble
        Out_Ready = 1'b1;
        In_Valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            In_Data = 32'h1111_0000 + 32'(i);
            #1;
            if (i > 0) chk("one_comb_ready", 32'(o_ready), 32'd1);
            tick();
            chk("pt_data",   s_data, 32'h1111_0000 + 32'(i));
            chk("pt_count",  32'(s_count), 32'd1);
            chk("pt_ready",  32'(s_ready), 32'd1);
            chk("one_pt_data", o_data, 32'h1111_0000 + 32'(i));
        end
        In_Valid = 1'b0;
        tick();
        chk("pt_drain", 32'(s_count), 32'd0);

        // backpressure
        Out_Ready = 1'b0;
        In_Valid  = 1'b1;
        In_Data   = 32'hA;
        tick();
        In_Data = 32'hB;
        tick();
        chk("bp_count2", 32'(s_count), 32'd2);
        chk("bp_ready0", 32'(s_ready), 32'd0);
        In_Data = 32'hC;
        tick();
        chk("bp_hold_count", 32'(s_count), 32'd2);
        chk("bp_head_a", s_data, 32'hA);
        Out_Ready = 1'b1;
        tick();
        chk("bp_head_b", s_data, 32'hB);
        chk("bp_ready1", 32'(s_ready), 32'd1);
        tick();
        chk("bp_head_c", s_data, 32'hC);
        In_Valid = 1'b0;
        tick();
        chk("bp_drain", 32'(s_count), 32'd0);

        // flush while FULL drops a same-cycle accept
        Out_Ready = 1'b0;
        In_Valid  = 1'b1;
        In_Data   = 32'h77;
        tick();
        Flush   = 1'b1;
        In_Data = DEAD;
        tick();
        chk("fl_full_valid", 32'(s_valid), 32'd0);
        chk("fl_full_data",  s_data, NOP);
        Flush    = 1'b0;
        In_Valid = 1'b0;
        tick();

        // flush while in SKID
        In_Valid = 1'b1;
        In_Data  = 32'h1;
        tick();
        In_Data = 32'h2;
        tick();
        chk("fl_skid_pre", 32'(s_count), 32'd2);
        Flush   = 1'b1;
        In_Data = DEAD;
        tick();
        chk("fl_skid_valid", 32'(s_valid), 32'd0);
        chk("fl_skid_count", 32'(s_count), 32'd0);
        chk("fl_skid_data",  s_data, NOP);
        Flush     = 1'b0;
        In_Valid  = 1'b0;
        Out_Ready = 1'b1;
        repeat (3) tick();
        chk("fl_after_valid", 32'(s_valid), 32'd0);

        // reset beats flush and accept
        Out_Ready = 1'b0;
        In_Valid  = 1'b1;
        In_Data   = 32'h4;
        tick();
        chk("rp_full", 32'(s_count), 32'd1);
        RST     = 1'b1;
        Flush   = 1'b1;
        In_Data = 32'h9;
        tick();
        chk("rp_valid", 32'(s_valid), 32'd0);
        chk("rp_data",  s_data, NOP);
        RST     = 1'b0;
        Flush   = 1'b0;
        In_Data = 32'h5;
        tick();
        chk("rp_accept5", s_data, 32'h5);
        chk("rp_count1",  32'(s_count), 32'd1);
        In_Data = 32'h6;
        tick();
        chk("rs_skid", 32'(s_count), 32'd2);
        RST = 1'b1;
        tick();
        chk("rs_count", 32'(s_count), 32'd0);
        chk("rs_ready", 32'(s_ready), 32'd1);
        RST      = 1'b0;
        In_Valid = 1'b0;
        tick();

        chk("dead_never_out", 32'(saw_dead), 32'd0);
        watch_dead = 1'b0;

        // random valid/ready against the model
        for (int i = 0; i < 1000; i++) begin
            In_Valid  = ($urandom_range(0, 3) != 0);
            Out_Ready = ($urandom_range(0, 2) != 0);
            In_Data   = $urandom;
            tick();
        end
        In_Valid  = 1'b0;
        Out_Ready = 1'b1;
        repeat (3) tick();
        chk("final_empty_s", 32'(s_count), 32'd0);
        chk("final_empty_o", 32'(o_count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
